// File: rtl/lc3b_mem_responder.sv
// rtl/lc3b_mem_responder.sv - LC-3b memory-side responder with a fixed response latency.
// Optional MEM_RESPONDER_STATS_EN adds saturating read/write completion counters.
module lc3b_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        proto_err
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [15:0]           wdata_q;
  logic [1:0]            be_q;
  logic                  op_write;
  logic                  req;
  logic [15:0]           mem [DEPTH];

  assign req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mem_resp  <= 1'b0;
      mem_rdata <= 16'h0000;
      proto_err <= 1'b0;
`ifdef MEM_RESPONDER_STATS_EN
      rd_count  <= 16'h0000;
      wr_count  <= 16'h0000;
`endif
    end else begin
      mem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q    <= mem_address[DEPTH_LOG2:1];
            wdata_q  <= mem_wdata;
            be_q     <= mem_byte_enable;
            op_write <= mem_write;
            cnt      <= LAT_M1;
            if (mem_read && mem_write) proto_err <= 1'b1;
            state    <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          // A dropped request means the CPU gave up; nothing may be written.
          if (!req) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            proto_err <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RESP;
          end
        end
        RESP: begin
          mem_resp <= 1'b1;
          state    <= IDLE;
          if (!op_write) mem_rdata <= mem[idx_q];
`ifdef MEM_RESPONDER_STATS_EN
          if (op_write) begin
            if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
          end else begin
            if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is never cleared; only the response cycle of a write touches it.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && op_write) begin
      if (be_q[0]) mem[idx_q][7:0]  <= wdata_q[7:0];
      if (be_q[1]) mem[idx_q][15:8] <= wdata_q[15:8];
    end
  end

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb/tb_lc3b_mem_responder.sv - self-checking bench for lc3b_mem_responder (LATENCY=4, DEPTH_LOG2=10).
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        proto_err;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  lc3b_mem_responder #(.DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .proto_err       (proto_err)
`ifdef MEM_RESPONDER_STATS_EN
    ,
    .rd_count        (rd_count),
    .wr_count        (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[12];
  logic [15:0] model [int];
  logic [15:0] last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one request at a negedge, hold it until mem_resp, then release.
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        output logic [15:0] rdata, output int lat);
    bit got;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = wdata; mem_byte_enable = be;
    @(posedge clk);
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (mem_resp) got = 1;
    end
    rdata = mem_rdata;
    mem_read = 0; mem_write = 0;
    if (!got) lat = 99;
    @(posedge clk); #1;
    chk("resp_one_cycle", {31'd0, mem_resp}, 32'd0);
  endtask

  logic [15:0] rdata;
  int          lat;

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; mem_address = 0; mem_wdata = 0; mem_byte_enable = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("reset_resp", {31'd0, mem_resp}, 32'd0);
    chk("reset_rdata", {16'd0, mem_rdata}, 32'd0);
    chk("reset_proto_err", {31'd0, proto_err}, 32'd0);

    tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000};
    tbl[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF};
    tbl[2]  = '{1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 16'hBEEF};
    tbl[3]  = '{1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 16'hBEEF};
    tbl[4]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hAB34};
    tbl[5]  = '{1'b0, 1'b1, 16'h0021, 16'h00CD, 2'b01, 16'hAB34};
    tbl[6]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hABCD};
    tbl[7]  = '{1'b1, 1'b0, 16'h0811, 16'h0000, 2'b00, 16'hBEEF};
    tbl[8]  = '{1'b0, 1'b1, 16'h0040, 16'h2222, 2'b11, 16'hBEEF};
    tbl[9]  = '{1'b0, 1'b1, 16'h0040, 16'h7777, 2'b00, 16'hBEEF};
    tbl[10] = '{1'b1, 1'b0, 16'h0041, 16'h0000, 2'b00, 16'h2222};
    tbl[11] = '{1'b1, 1'b0, 16'hF810, 16'h0000, 2'b00, 16'hBEEF};

    for (int i = 0; i < 12; i++) begin
      do_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, rdata, lat);
      chk($sformatf("tbl%0d_latency", i), lat, 32'd4);
      chk($sformatf("tbl%0d_rdata", i), {16'd0, rdata}, {16'd0, tbl[i].exp});
    end
`ifdef MEM_RESPONDER_STATS_EN
    chk("stats_rd_count", {16'd0, rd_count}, 32'd6);
    chk("stats_wr_count", {16'd0, wr_count}, 32'd6);
`endif
    last_rd = 16'hBEEF;

    // Randomised traffic over a 16-word pool at word indices 0x100..0x10F with random alias bits.
    for (int w = 0; w < 16; w++) begin
      logic [15:0] v;
      v = 16'($urandom);
      do_txn(1'b0, 1'b1, 16'(((256 + w) * 2)), v, 2'b11, rdata, lat);
      model[256 + w] = v;
      chk("pre_latency", lat, 32'd4);
    end
    for (int n = 0; n < 40; n++) begin
      int          w;
      logic [15:0] a, v, exp;
      logic [1:0]  b;
      logic        is_wr;
      w = 256 + int'($urandom_range(0, 15));
      a = 16'(($urandom & 32'hF800) | (w * 2) | ($urandom & 1));
      v = 16'($urandom);
      b = 2'($urandom);
      is_wr = 1'($urandom);
      do_txn(!is_wr, is_wr, a, v, b, rdata, lat);
      if (is_wr) begin
        if (b[0]) model[w] = (model[w] & 16'hFF00) | (v & 16'h00FF);
        if (b[1]) model[w] = (model[w] & 16'h00FF) | (v & 16'hFF00);
        exp = last_rd;
      end else begin
        exp = model[w];
        last_rd = exp;
      end
      chk($sformatf("rnd%0d_latency", n), lat, 32'd4);
      chk($sformatf("rnd%0d_rdata", n), {16'd0, rdata}, {16'd0, exp});
    end

    // Read dropped two cycles in: aborted, no response, sticky error.
    chk("pre_abort_proto_err", {31'd0, proto_err}, 32'd0);
    begin
      bit seen;
      @(negedge clk); mem_read = 1; mem_address = 16'h0020;
      @(posedge clk); @(posedge clk);
      @(negedge clk); mem_read = 0;
      seen = 0;
      repeat (10) begin @(posedge clk); #1; if (mem_resp) seen = 1; end
      chk("abort_no_resp", {31'd0, seen}, 32'd0);
      chk("abort_proto_err", {31'd0, proto_err}, 32'd1);
    end
    do_txn(1'b1, 1'b0, 16'h0010, 16'h0, 2'b00, rdata, lat);
    chk("post_abort_latency", lat, 32'd4);
    chk("post_abort_rdata", {16'd0, rdata}, 32'h0000BEEF);

    // Request held across a response starts the next one LATENCY+1 cycles later.
    begin
      int l1, l2;
      @(negedge clk); mem_read = 1; mem_address = 16'h0020;
      @(posedge clk);
      l1 = 0; while (l1 < 20) begin @(posedge clk); #1; l1++; if (mem_resp) break; end
      l2 = 0; while (l2 < 20) begin @(posedge clk); #1; l2++; if (mem_resp) break; end
      mem_read = 0;
      chk("b2b_first_latency", l1, 32'd4);
      chk("b2b_spacing", l2, 32'd5);
      chk("b2b_rdata", {16'd0, mem_rdata}, 32'h0000ABCD);
    end

    // Reset during BUSY of a write discards it.
    do_txn(1'b0, 1'b1, 16'h0030, 16'h1357, 2'b11, rdata, lat);
    begin
      bit seen;
      @(negedge clk); mem_write = 1; mem_address = 16'h0030; mem_wdata = 16'hFFFF; mem_byte_enable = 2'b11;
      @(posedge clk); @(posedge clk);
      @(negedge clk); rst = 1; mem_write = 0;
      @(negedge clk); rst = 0;
      seen = 0;
      repeat (8) begin @(posedge clk); #1; if (mem_resp) seen = 1; end
      chk("rst_no_resp", {31'd0, seen}, 32'd0);
      chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
      chk("rst_rdata", {16'd0, mem_rdata}, 32'd0);
`ifdef MEM_RESPONDER_STATS_EN
      chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
      chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
`endif
    end
    do_txn(1'b1, 1'b0, 16'h0030, 16'h0, 2'b00, rdata, lat);
    chk("rst_read_latency", lat, 32'd4);
    chk("rst_read_prior", {16'd0, rdata}, 32'h00001357);

    // Read and write together: treated as a write, error flag sticks.
    do_txn(1'b1, 1'b1, 16'h0004, 16'h5555, 2'b11, rdata, lat);
    chk("both_latency", lat, 32'd4);
    chk("both_rdata_unchanged", {16'd0, rdata}, 32'h00001357);
    chk("both_proto_err", {31'd0, proto_err}, 32'd1);
    do_txn(1'b1, 1'b0, 16'h0004, 16'h0, 2'b00, rdata, lat);
    chk("both_readback", {16'd0, rdata}, 32'h00005555);
    chk("both_proto_err_sticky", {31'd0, proto_err}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
